bus_dma_arbiter: RTL
====================

// Module: bus_dma_arbiter
// PURPOSE
//  Shares the unibus-style RAM port between the CPU and NREQ DMA devices (IDE, future RK/TM).
//  Round-robin among DMA requesters, bounded bursts, guaranteed CPU holdoff window between bursts.
//  Sits between the CPU bus port, the iopage DMA masters and the RAM interface.
//  Replaces the single-requester fixed-burst grant logic.
// PARAMETERS
//  NREQ     2   number of DMA requesters (1..4)
//  BURST    4   max consecutive DMA-owned cycles per grant (1..15)
//  CPU_MIN  1   min CPU-owned cycles after a burst before re-arbitration (1..15)
// PORTS
//  clk             in   1        system clock
//  reset           in   1        asynchronous, active-high
//  bus_arbitrate   in   1        CPU permits DMA takeover this cycle
//  bus_addr        in   22       CPU address
//  bus_data_in     in   16       CPU write data
//  bus_rd, bus_wr  in   1 each   CPU strobes
//  bus_byte_op     in   1        CPU byte access
//  cpu_ram_access  in   1        CPU address decodes to RAM
//  dma_req         in   NREQ     per-device request, level
//  dma_addr        in   NREQ*18  packed, device i at [18*i+17:18*i]
//  dma_data        in   NREQ*16  packed write data
//  dma_rd, dma_wr  in   NREQ     per-device strobes
//  bus_ack         out  1        CPU owns RAM port (registered)
//  dma_ack         out  NREQ     one-hot DMA grant (registered)
//  ram_addr        out  22       muxed address; DMA = {4'b0,dma_addr[i]}
//  ram_data_out    out  16       muxed write data
//  ram_rd, ram_wr  out  1 each   muxed strobes
//  ram_byte_op     out  1        CPU: bus_byte_op; DMA: 0
// BEHAVIOUR
//  Reset (async): state=CPU, bus_ack=1, dma_ack=0, last=NREQ-1, burst_cnt=0, hold_cnt=0.
//  States: CPU, DMA. bus_ack = (state==CPU); exactly one of bus_ack / dma_ack bits set, always.
//  CPU: if hold_cnt!=0, decrement, no arbitration. Else if |dma_req && bus_arbitrate, pick winner
//   = first requester at or after (last+1) mod NREQ; next cycle state=DMA, dma_ack[win]=1,
//   last=win, burst_cnt=BURST-1. Latency req->ack: 1 clk after the sampling edge.
//  DMA: each cycle is one granted RAM cycle for dma_ack owner. Return to CPU on next edge when
//   owner's dma_req=0 or burst_cnt==0; else burst_cnt--. On return hold_cnt=CPU_MIN-1.
//  Burst length = cycles dma_ack high: min 1, max BURST. Winner never changes mid-burst.
//  A requester that drops dma_req is released the next edge (that one cycle still counts as granted).
//  Mux: bus_ack=1 -> ram_rd=bus_rd&cpu_ram_access, ram_wr=bus_wr&cpu_ram_access, CPU addr/data.
//   DMA owner i -> ram_rd=dma_rd[i], ram_wr=dma_wr[i], dma_addr/dma_data of i. Mux is combinational
//   from registered grant; no other requester's strobes reach RAM.
//  bus_arbitrate only sampled in CPU state; ignored during DMA.
//  Simultaneous requests: rotation pointer decides; pointer advances only on grant.
//  NREQ=1: rotation degenerates to device 0; rules above unchanged.
//  Reset mid-burst: grant drops immediately (async), CPU owns port; no RAM strobe from DMA.
// TESTING
//  1 Reset -> bus_ack=1, dma_ack=0; ram_addr follows bus_addr=22'o017000.
//  2 dma_req=01, bus_arbitrate=1 held, BURST=4 -> dma_ack=01 for exactly 4 clks, then bus_ack=1
//    for CPU_MIN clk, then re-grant.
//  3 dma_req=11 constant -> grants alternate 01,10,01 with a CPU cycle between each burst.
//  4 dma_req=01 with bus_arbitrate=0 for 10 clks -> no grant; grant 1 clk after bus_arbitrate=1.
//  5 Device 1 drops req after 2 granted clks -> bus_ack=1 next edge; dma_wr of device 0 never reaches ram_wr.
//  6 Assert reset during DMA cycle 2 -> bus_ack=1, dma_ack=0, ram_wr=0 same cycle; rotation restarts at device 0.

Source files
------------

// File: rtl/bus_dma_arbiter.sv
// RAM port arbiter between the CPU bus and NREQ DMA masters.
// Round-robin grants, bounded bursts and a minimum CPU window after each burst.
module bus_dma_arbiter #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned BURST   = 4,
    parameter int unsigned CPU_MIN = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               bus_arbitrate,
    input  logic [21:0]        bus_addr,
    input  logic [15:0]        bus_data_in,
    input  logic               bus_rd,
    input  logic               bus_wr,
    input  logic               bus_byte_op,
    input  logic               cpu_ram_access,
    input  logic [NREQ-1:0]    dma_req,
    input  logic [NREQ*18-1:0] dma_addr,
    input  logic [NREQ*16-1:0] dma_data,
    input  logic [NREQ-1:0]    dma_rd,
    input  logic [NREQ-1:0]    dma_wr,
    output logic               bus_ack,
    output logic [NREQ-1:0]    dma_ack,
    output logic [21:0]        ram_addr,
    output logic [15:0]        ram_data_out,
    output logic               ram_rd,
    output logic               ram_wr,
    output logic               ram_byte_op
);

    localparam int unsigned PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW  = 4;
    localparam int unsigned AW  = 22;
    localparam int unsigned DAW = 18;
    localparam int unsigned DW  = 16;

    typedef enum logic {
        ST_CPU = 1'b0,
        ST_DMA = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic            bus_ack_q, bus_ack_d;
    logic [NREQ-1:0] dma_ack_q, dma_ack_d;
    logic [PW-1:0]   last_q, last_d;
    logic [CW-1:0]   burst_cnt_q, burst_cnt_d;
    logic [CW-1:0]   hold_cnt_q, hold_cnt_d;

    logic            win_found;
    logic [PW-1:0]   win_idx;

    // Candidate k steps past the last winner, wrapping modulo NREQ.
    function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] last, input int unsigned k);
        int unsigned s;
        s = (32'(last) + 32'd1 + k) % NREQ;
        return PW'(s);
    endfunction

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!win_found && dma_req[rr_idx(last_q, k)]) begin
                win_found = 1'b1;
                win_idx   = rr_idx(last_q, k);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_CPU;
            bus_ack_q   <= 1'b1;
            dma_ack_q   <= '0;
            last_q      <= PW'(NREQ - 1);
            burst_cnt_q <= '0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            bus_ack_q   <= bus_ack_d;
            dma_ack_q   <= dma_ack_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    // The current owner is always last_q while in ST_DMA.
    always_comb begin
        state_d     = state_q;
        bus_ack_d   = bus_ack_q;
        dma_ack_d   = dma_ack_q;
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        unique case (state_q)
            ST_CPU: begin
                if (hold_cnt_q != '0) begin
                    hold_cnt_d = hold_cnt_q - CW'(1);
                end else if (win_found && bus_arbitrate) begin
                    state_d            = ST_DMA;
                    bus_ack_d          = 1'b0;
                    dma_ack_d          = '0;
                    dma_ack_d[win_idx] = 1'b1;
                    last_d             = win_idx;
                    burst_cnt_d        = CW'(BURST - 1);
                end
            end
            ST_DMA: begin
                if (!dma_req[last_q] || burst_cnt_q == '0) begin
                    state_d    = ST_CPU;
                    bus_ack_d  = 1'b1;
                    dma_ack_d  = '0;
                    hold_cnt_d = CW'(CPU_MIN - 1);
                end else begin
                    burst_cnt_d = burst_cnt_q - CW'(1);
                end
            end
            default: begin
                state_d   = ST_CPU;
                bus_ack_d = 1'b1;
                dma_ack_d = '0;
            end
        endcase
    end

    // RAM mux driven only by the registered grant, so a non-owner can never strobe RAM.
    always_comb begin
        ram_addr     = bus_addr;
        ram_data_out = bus_data_in;
        ram_rd       = bus_rd & cpu_ram_access;
        ram_wr       = bus_wr & cpu_ram_access;
        ram_byte_op  = bus_byte_op;
        if (!bus_ack_q) begin
            ram_addr     = '0;
            ram_data_out = '0;
            ram_rd       = 1'b0;
            ram_wr       = 1'b0;
            ram_byte_op  = 1'b0;
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (dma_ack_q[i]) begin
                    ram_addr     = {4'b0000, dma_addr[DAW*i +: DAW]};
                    ram_data_out = dma_data[DW*i +: DW];
                    ram_rd       = dma_rd[i];
                    ram_wr       = dma_wr[i];
                end
            end
        end
    end

    assign bus_ack = bus_ack_q;
    assign dma_ack = dma_ack_q;

endmodule
